noc_traffic_sequencer: RTL
==========================

// Module: noc_traffic_sequencer
// PURPOSE
//  Run controller for the mesh traffic generators: arms the per-PE generators, waits for
//  injection done, polls per-PE receive counters until every injected packet has arrived,
//  then reports cycle count and pass/fail. Sits beside the PE generator array and replaces
//  bench-side polling, so throughput runs can be launched from a CSR or a host.
// PARAMETERS
//  X            10      mesh columns
//  Y            10      mesh rows
//  NUM_PACKETS  1000    packets injected per enabled PE
//  CNT_W        32      width of each receive counter, total_rx and cycle_count
//  TIMEOUT      1<<24   cycles allowed from ARM to completion (NOC_SEQ_TIMEOUT_EN only)
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  cfg_go         in   1          level; a rising edge seen in IDLE launches a run
//  cfg_enable     in   X*Y        per-PE injection enable, sampled at launch
//  gen_done       in   1          generator array: all injection finished
//  receive_count  in   CNT_W*X*Y  per-PE received-packet counters, PE i at [i*CNT_W+:CNT_W]
//  start          out  1          run enable to the generators
//  enable_send    out  X*Y        latched cfg_enable, driven while start=1
//  busy           out  1          high from launch until REPORT
//  result_valid   out  1          sticky; cleared by the next launch
//  pass           out  1          total_rx == expected
//  err_over       out  1          total_rx > expected
//  err_timeout    out  1          watchdog expired
//  total_rx       out  CNT_W      last completed scan sum
//  cycle_count    out  CNT_W      cycles from entering ARM to completion, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, go_q=0. rst mid-run aborts and returns to IDLE in 1 cycle.
//  expected = popcount(latched enable) * NUM_PACKETS, computed once at launch in CNT_W bits.
//  FSM: IDLE -> ARM -> WAIT_LOW -> WAIT_DONE -> SCAN -> REPORT -> IDLE.
//   IDLE: cfg_go & ~go_q -> latch enable, clear status and result_valid, goto ARM.
//         If the latched enable is all zero, go straight to REPORT: pass=1, cycle_count=0.
//   ARM: start=1, enable_send=mask; 1 cycle; cycle_count starts at 0 here.
//   WAIT_LOW: wait for gen_done=0; this handles a stale done left over from a previous run.
//   WAIT_DONE: wait for gen_done=1.
//   SCAN: walk idx 0..X*Y-1 at one PE per cycle; acc += receive_count[idx].
//         At the last idx, total_rx <= acc + count, in CNT_W bits with wrap.
//         If the sum equals expected, goto REPORT. If it is greater, set err_over and goto REPORT.
//         Otherwise restart the scan with acc=0 and idx=0.
//   REPORT: start=0, enable_send=0, busy=0, result_valid=1, pass=(~err_over & ~err_timeout).
//           Goto IDLE the next cycle.
//  cycle_count increments every cycle in ARM..SCAN and holds at all-ones.
//  Latency: REPORT is reached X*Y+1 cycles after the last packet arrives, worst case
//  2*X*Y+1 because a partial scan is discarded.
//  cfg_go edges while busy=1 are ignored. go_q tracks cfg_go in every state.
//  Counters are read through an unregistered mux. receive_count must be synchronous to clk.
// CONFIGURATION
//  NOC_SEQ_TIMEOUT_EN defined: a watchdog counts in ARM..SCAN. When it reaches TIMEOUT it
//   sets err_timeout, latches the current cycle_count and total_rx, and goes to REPORT.
//  NOC_SEQ_TIMEOUT_EN undefined: no watchdog, err_timeout tied to 0, the run may wait forever.
// STRUCTURE
//  Shared include noc_seq_defs.vh: FSM state localparams (3-bit encoding) and the
//   CNT_W default. X, Y and the width derivations follow the NoC-wide include.
//  One sub-module, noc_rx_count_scanner: idx counter, accumulator, last/total outputs,
//   and a restart input. The sequencer owns the FSM, expected value, watchdog and status.
// TESTING
//  1. X=Y=2, NUM_PACKETS=4, mask=4'hF, model delivers 16 packets, done after 50 cycles
//     -> REPORT with pass=1, total_rx=16, cycle_count >= 50, start low.
//  2. mask=4'b0101 -> expected=8. Deliver 8 packets -> pass=1.
//     Deliver 9 packets -> err_over=1, pass=0.
//  3. mask=0 -> result_valid within 2 cycles of the go edge, pass=1, cycle_count=0,
//     start never asserted.
//  4. gen_done held high from a prior run at launch -> the FSM stays in WAIT_LOW until
//     done falls, then completes normally.
//  5. NOC_SEQ_TIMEOUT_EN, TIMEOUT=200, 1 packet withheld -> err_timeout=1 at cycle 200,
//     pass=0, total_rx=15.
//  6. rst asserted in SCAN -> next cycle all outputs 0 and IDLE.
//     cfg_go pulsed while busy -> no relaunch.

Source files
------------

// File: rtl/noc_traffic_sequencer_pkg.sv
// noc_traffic_sequencer_pkg: FSM state encoding and counter-width default shared by the run sequencer
package noc_traffic_sequencer_pkg;
    localparam int CNT_W_DEF = 32;
    typedef enum logic [2:0] {IDLE, ARM, WAIT_LOW, WAIT_DONE, SCAN, REPORT} state_t;
endpackage

// File: rtl/noc_rx_count_scanner.sv
// noc_rx_count_scanner: walks the per-PE receive counters one PE per cycle and sums them
//   clk, rst       clock, synchronous active-high reset
//   restart        clears idx and accumulator
//   en             advance one PE; wraps to PE 0 with a cleared accumulator after the last one
//   receive_count  packed per-PE counters, PE i at [i*CNT_W+:CNT_W]
//   last           idx is on the final PE
//   total          accumulator plus the current PE counter, wrapping in CNT_W bits
module noc_rx_count_scanner #(
    parameter int N = 100,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               en,
    input  logic [CNT_W*N-1:0] receive_count,
    output logic               last,
    output logic [CNT_W-1:0]   total
);
    localparam int IW = N > 1 ? $clog2(N) : 1;
    logic [IW-1:0] idx;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] cnt [N];
    for (genvar i = 0; i < N; i++) begin : g_cnt
        assign cnt[i] = receive_count[i*CNT_W +: CNT_W];
    end
    assign last = idx == IW'(N - 1);
    assign total = acc + cnt[idx];
    always_ff @(posedge clk) begin
        if (rst || restart || (en && last)) begin
            idx <= '0;
            acc <= '0;
        end else if (en) begin
            idx <= idx + IW'(1);
            acc <= total;
        end
    end
endmodule

// File: rtl/noc_traffic_sequencer.sv
// noc_traffic_sequencer: arms the PE traffic generators, waits for injection done, polls receive counters to completion
//   in : clk, rst (sync, active-high), cfg_go (launch on rising edge in IDLE), cfg_enable (per-PE mask),
//        gen_done (generator array finished), receive_count (per-PE counters)
//   out: start, enable_send, busy, result_valid (sticky), pass, err_over, err_timeout, total_rx, cycle_count
//   NOC_SEQ_TIMEOUT_EN: when defined, a watchdog ends the run after TIMEOUT cycles with err_timeout set
module noc_traffic_sequencer import noc_traffic_sequencer_pkg::*; #(
    parameter int X = 10,
    parameter int Y = 10,
    parameter int NUM_PACKETS = 1000,
    parameter int CNT_W = CNT_W_DEF
`ifdef NOC_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT = 1 << 24
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_go,
    input  logic [X*Y-1:0]       cfg_enable,
    input  logic                 gen_done,
    input  logic [CNT_W*X*Y-1:0] receive_count,
    output logic                 start,
    output logic [X*Y-1:0]       enable_send,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 pass,
    output logic                 err_over,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     total_rx,
    output logic [CNT_W-1:0]     cycle_count
);
    state_t state;
    logic go_q, launch, running, last, scan_end, tmo, fin;
    logic [CNT_W-1:0] expected, total;
    always_comb begin
        launch = state == IDLE && cfg_go && !go_q;
        running = state inside {ARM, WAIT_LOW, WAIT_DONE, SCAN};
        scan_end = state == SCAN && last && total >= expected;
        fin = scan_end || tmo;
    end
    noc_rx_count_scanner #(.N(X*Y), .CNT_W(CNT_W)) u_scan (
        .clk(clk),
        .rst(rst),
        .restart(state != SCAN),
        .en(state == SCAN),
        .receive_count(receive_count),
        .last(last),
        .total(total)
    );
`ifdef NOC_SEQ_TIMEOUT_EN
    logic [31:0] wd;
    assign tmo = running && wd == 32'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            wd <= '0;
            err_timeout <= 1'b0;
        end else if (running) begin
            wd <= wd + 32'd1;
            if (tmo) err_timeout <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err_timeout = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            go_q <= 1'b0;
            start <= 1'b0;
            enable_send <= '0;
            busy <= 1'b0;
            result_valid <= 1'b0;
            pass <= 1'b0;
            err_over <= 1'b0;
            total_rx <= '0;
            cycle_count <= '0;
            expected <= '0;
        end else begin
            go_q <= cfg_go;
            if (running) cycle_count <= &cycle_count ? cycle_count : cycle_count + CNT_W'(1);
            if (state == SCAN && last) total_rx <= total;
            if (launch) begin
                // an empty mask has nothing to wait for, so it reports a pass immediately
                expected <= CNT_W'($countones(cfg_enable)) * CNT_W'(NUM_PACKETS);
                enable_send <= cfg_enable;
                start <= cfg_enable != '0;
                busy <= cfg_enable != '0;
                result_valid <= cfg_enable == '0;
                pass <= cfg_enable == '0;
                err_over <= 1'b0;
                total_rx <= '0;
                cycle_count <= '0;
                state <= cfg_enable == '0 ? REPORT : ARM;
            end else if (fin) begin
                state <= REPORT;
                start <= 1'b0;
                enable_send <= '0;
                busy <= 1'b0;
                result_valid <= 1'b1;
                err_over <= scan_end && total != expected;
                pass <= !tmo && total == expected;
            end else begin
                // WAIT_LOW absorbs a done level left high by the previous run
                state <= state == ARM ? WAIT_LOW :
                         state == WAIT_LOW && !gen_done ? WAIT_DONE :
                         state == WAIT_DONE && gen_done ? SCAN :
                         state == REPORT ? IDLE : state;
            end
        end
    end
endmodule
